klein_key_arbiter: RTL and testbench

- Shares one `klein_keyschedule` instance between NREQ requesters, e.g. the encrypt and decrypt KLEIN cores.
- Arbitrates round-robin, loads the winning requester's 64-bit master key and pulses the schedule start.
- Waits for the schedule to finish, captures the final round key and returns it to the owner with a one-cycle done pulse.
- A watchdog flags a schedule that never completes.

---
 rtl/klein_key_arbiter.sv | 273 +++++++++++++++++++++++++++
 tb/tb_klein_key_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/klein_key_arbiter.sv
// klein_key_arbiter
//   Shares one KLEIN-64 key-schedule engine between NREQ requesters.
//   Requesters are served round-robin. The owner's 64-bit master key is
//   latched, the schedule is started, and the final (13th) round key is
//   captured and returned with a one-cycle done pulse. A watchdog ends a
//   service that never completes, returning okey=0 with oerr.
//
// Ports
//   iclk    in   1        clock, rising edge
//   ireset  in   1        synchronous active-high reset (also resets schedule)
//   ireq    in   NREQ     per-requester request level
//   ikey    in   64*NREQ  master keys, requester i at [64*i +: 64]
//   ogrant  out  NREQ     one-hot owner, START through DONE
//   odone   out  NREQ     one-cycle pulse to the owner when okey is valid
//   oerr    out  1        one-cycle pulse with odone on timeout
//   okey    out  64       last captured final round key
//   obusy   out  1        high whenever the FSM is not IDLE
//
// klein_keyschedule
//   Iterative KLEIN-64 key schedule, one round per cycle. istart loads
//   ikey; oready pulses 12 cycles after istart and the final round key is
//   on okey the following cycle.

module klein_keyschedule (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        istart,
  input  logic [63:0] ikey,
  output logic        oready,
  output logic [63:0] okey
);

  logic [63:0] key_r;
  logic [3:0]  rnd_r;
  logic        active_r;

  function automatic logic [3:0] klein_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h7;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'h9;
      4'h4: y = 4'h1;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h0;
      4'h8: y = 4'hC;  4'h9: y = 4'h3;  4'hA: y = 4'h2;  4'hB: y = 4'h6;
      4'hC: y = 4'h8;  4'hD: y = 4'hE;  4'hE: y = 4'hD;  4'hF: y = 4'h5;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // One key-schedule round: byte-rotate both halves, Feistel-like mix,
  // add the round counter into byte 2 of the left half and pass bytes 1..2
  // of the right half through the S-box.
  function automatic logic [63:0] klein_round(input logic [63:0] k, input logic [7:0] rc);
    logic [31:0] a_rot;
    logic [31:0] b_rot;
    logic [31:0] a_n;
    logic [31:0] b_n;
    a_rot       = {k[55:32], k[63:56]};
    b_rot       = {k[23:0],  k[31:24]};
    a_n         = b_rot;
    b_n         = a_rot ^ b_rot;
    a_n[15:8]   = a_n[15:8] ^ rc;
    b_n[23:20]  = klein_sbox(b_n[23:20]);
    b_n[19:16]  = klein_sbox(b_n[19:16]);
    b_n[15:12]  = klein_sbox(b_n[15:12]);
    b_n[11:8]   = klein_sbox(b_n[11:8]);
    return {a_n, b_n};
  endfunction

  // Round iteration; rnd_r counts completed rounds, oready fires during the
  // cycle that applies round 12 so the final key follows one cycle later.
  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      key_r    <= 64'h0;
      rnd_r    <= 4'd0;
      active_r <= 1'b0;
      oready   <= 1'b0;
    end else begin
      oready <= 1'b0;
      if (istart) begin
        key_r    <= ikey;
        rnd_r    <= 4'd0;
        active_r <= 1'b1;
      end else if (active_r) begin
        key_r  <= klein_round(key_r, {4'd0, rnd_r + 4'd1});
        rnd_r  <= rnd_r + 4'd1;
        oready <= (rnd_r == 4'd10);
        if (rnd_r == 4'd11) begin
          active_r <= 1'b0;
        end
      end
    end
  end

  assign okey = key_r;

endmodule

module klein_key_arbiter #(
  parameter int NREQ     = 2,
  parameter int WAIT_MAX = 16
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic [NREQ-1:0]    ireq,
  input  logic [64*NREQ-1:0] ikey,
  output logic [NREQ-1:0]    ogrant,
  output logic [NREQ-1:0]    odone,
  output logic               oerr,
  output logic [63:0]        okey,
  output logic               obusy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   rr_r;
  logic [IW-1:0]   owner_r;
  logic [IW-1:0]   pick_s;
  logic [IW-1:0]   cand_s;
  logic            any_req_s;
  logic [63:0]     key_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            wait_last_s;
  logic            ks_start_r;
  logic            ks_ready;
  logic [63:0]     ks_okey;
  logic            ks_reset_n_s;
  logic [NREQ-1:0] grant_d;
  logic [NREQ-1:0] done_d;
  logic            err_d;
  logic            busy_d;
  logic            start_d;

  assign ks_reset_n_s = ~ireset;

  klein_keyschedule u_ks (
    .iclk     (iclk),
    .ireset_n (ks_reset_n_s),
    .istart   (ks_start_r),
    .ikey     (key_r),
    .oready   (ks_ready),
    .okey     (ks_okey)
  );

  // Round-robin pick: scan from the farthest offset down so the requester
  // closest at/after rr_r is the last one written and wins.
  always_comb begin
    any_req_s = 1'b0;
    pick_s    = rr_r;
    cand_s    = rr_r;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = IW'((int'(rr_r) + k) % NREQ);
      if (ireq[cand_s]) begin
        any_req_s = 1'b1;
        pick_s    = cand_s;
      end else begin
        pick_s    = pick_s;
      end
    end
  end

  // Counter value at which the current WAIT cycle is the WAIT_MAX-th one.
  assign wait_last_s = (wait_cnt_r == CW'(WAIT_MAX - 1));

  // State register.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ks_ready takes priority over the watchdog.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) state_s = S_START;
        else           state_s = S_IDLE;
      end
      S_START:   state_s = S_WAIT;
      S_WAIT: begin
        if (ks_ready)         state_s = S_CAPTURE;
        else if (wait_last_s) state_s = S_DONE;
        else                  state_s = S_WAIT;
      end
      S_CAPTURE: state_s = S_DONE;
      S_DONE:    state_s = S_IDLE;
      default:   state_s = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe. Entering DONE straight from WAIT can only
  // mean the watchdog expired.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = (state_s != S_IDLE);
    start_d = (state_s == S_START);
    if (state_s == S_START) begin
      grant_d[pick_s] = 1'b1;
    end else if (state_s != S_IDLE) begin
      grant_d[owner_r] = 1'b1;
    end else begin
      grant_d = '0;
    end
    if (state_s == S_DONE) begin
      done_d[owner_r] = 1'b1;
      err_d           = (state_r == S_WAIT);
    end else begin
      done_d = '0;
      err_d  = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      rr_r       <= '0;
      owner_r    <= '0;
      key_r      <= 64'h0;
      wait_cnt_r <= '0;
      ks_start_r <= 1'b0;
      ogrant     <= '0;
      odone      <= '0;
      oerr       <= 1'b0;
      okey       <= 64'h0;
      obusy      <= 1'b0;
    end else begin
      ogrant     <= grant_d;
      odone      <= done_d;
      oerr       <= err_d;
      obusy      <= busy_d;
      ks_start_r <= start_d;
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            owner_r <= pick_s;
            key_r   <= ikey[64*int'(pick_s) +: 64];
          end
        end
        S_START: wait_cnt_r <= '0;
        S_WAIT: begin
          wait_cnt_r <= wait_cnt_r + CW'(1);
          // Timeout: clear okey so it reads zero alongside odone/oerr.
          if (!ks_ready && wait_last_s) begin
            okey <= 64'h0;
          end
        end
        S_CAPTURE: okey <= ks_okey;
        S_DONE: begin
          if (owner_r == IW'(NREQ - 1)) rr_r <= '0;
          else                          rr_r <= owner_r + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_klein_key_arbiter.sv
module tb_klein_key_arbiter;

  logic         iclk;
  logic         ireset;
  logic [1:0]   ireq;
  logic [127:0] ikey;
  logic [1:0]   ogrant;
  logic [1:0]   odone;
  logic         oerr;
  logic [63:0]  okey;
  logic         obusy;

  int tests_run;
  int tests_failed;

  klein_key_arbiter #(.NREQ(2), .WAIT_MAX(16)) dut (
    .iclk   (iclk),
    .ireset (ireset),
    .ireq   (ireq),
    .ikey   (ikey),
    .ogrant (ogrant),
    .odone  (odone),
    .oerr   (oerr),
    .okey   (okey),
    .obusy  (obusy)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb watchdog");
  end

  logic [3:0] sb_tab [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                              4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

  // Byte-oriented reference model of the 12-round KLEIN-64 key schedule.
  function automatic logic [63:0] gold_final(input logic [63:0] mk);
    logic [7:0]  s [8];
    logic [7:0]  t [8];
    logic [63:0] r;
    for (int j = 0; j < 8; j++) s[j] = mk[63 - 8*j -: 8];
    for (int rc = 1; rc <= 12; rc++) begin
      t[0] = s[5];        t[1] = s[6];        t[2] = s[7];        t[3] = s[4];
      t[4] = s[1] ^ s[5]; t[5] = s[2] ^ s[6]; t[6] = s[3] ^ s[7]; t[7] = s[0] ^ s[4];
      t[2] = t[2] ^ 8'(rc);
      t[5] = {sb_tab[t[5][7:4]], sb_tab[t[5][3:0]]};
      t[6] = {sb_tab[t[6][7:4]], sb_tab[t[6][3:0]]};
      for (int j = 0; j < 8; j++) s[j] = t[j];
    end
    for (int j = 0; j < 8; j++) r[63 - 8*j -: 8] = s[j];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  // One service: ireq applied at a negedge (cycle 0 ends at the next edge),
  // wait bounded for odone, check latency/owner/key/err, then obusy low.
  task automatic serve(input string name, input logic [1:0] req, input logic [1:0] exp_owner,
                       input logic [63:0] exp_key, input logic exp_err, input int exp_lat,
                       input bit keep_req, input int drop_at);
    int lat;
    int grant_bad;
    lat       = -1;
    grant_bad = 0;
    ireq      = req;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == drop_at - 1) ireq = 2'b00;
      if (ogrant !== exp_owner) grant_bad++;
      if (odone !== 2'b00) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_odone"}, 64'(odone), 64'(exp_owner));
    check({name, "_oerr"}, 64'(oerr), 64'(exp_err));
    check({name, "_okey"}, okey, exp_key);
    check({name, "_grant"}, 64'(grant_bad), 64'd0);
    if (!keep_req) ireq = 2'b00;
    tick();
    check({name, "_idle"}, {62'd0, obusy, odone != 2'b00}, 64'd0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [63:0] k0;
    logic [63:0] k1;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int quiet_bad;
    tests_run    = 0;
    tests_failed = 0;
    ireset       = 1'b1;
    ireq         = 2'b00;
    ikey         = 128'h0;

    // rr starts at 0: 01 -> 0, 10 -> 1, then 11 alternates 0 then 1.
    vecs[0] = '{2'b01, 64'h0000000000000000, 64'h1111111111111111, 2'b01};
    vecs[1] = '{2'b10, 64'h2222222222222222, 64'hFFFFFFFFFFFFFFFF, 2'b10};
    vecs[2] = '{2'b11, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2'b01};
    vecs[3] = '{2'b11, 64'h0F1E2D3C4B5A6978, 64'hDEADBEEFCAFEF00D, 2'b10};

    repeat (3) tick();
    ireset = 1'b0;
    tick();
    check("rst_ogrant", 64'(ogrant), 64'd0);
    check("rst_odone",  64'(odone),  64'd0);
    check("rst_oerr",   64'(oerr),   64'd0);
    check("rst_okey",   okey,        64'd0);
    check("rst_obusy",  64'(obusy),  64'd0);

    for (int v = 0; v < 4; v++) begin
      ikey = {vecs[v].k1, vecs[v].k0};
      serve($sformatf("vec%0d", v), vecs[v].req, vecs[v].exp_owner,
            gold_final(vecs[v].exp_owner[1] ? vecs[v].k1 : vecs[v].k0), 1'b0, 15, 1'b0, -1);
    end

    // Simultaneous held requests: 0, 1, 0 back to back (odone at 15, 31, 47).
    ikey = {64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};
    serve("sim_a", 2'b11, 2'b01, gold_final(64'h0), 1'b0, 15, 1'b1, -1);
    serve("sim_b", 2'b11, 2'b10, gold_final(64'hFFFFFFFFFFFFFFFF), 1'b0, 15, 1'b1, -1);
    serve("sim_c", 2'b11, 2'b01, gold_final(64'h0), 1'b0, 15, 1'b0, -1);

    // Fairness after serving requester 1 alone.
    ikey = {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A};
    serve("fair_1", 2'b10, 2'b10, gold_final(64'hA5A5A5A5A5A5A5A5), 1'b0, 15, 1'b0, -1);
    serve("fair_0", 2'b11, 2'b01, gold_final(64'h5A5A5A5A5A5A5A5A), 1'b0, 15, 1'b0, -1);

    // Timeout: schedule ready suppressed; DONE follows the 16th WAIT cycle.
    force dut.ks_ready = 1'b0;
    serve("tmo", 2'b01, 2'b01, 64'h0, 1'b1, 18, 1'b0, -1);
    release dut.ks_ready;

    // Reset mid-WAIT: ireset high during cycle 7, outputs cleared in cycle 8.
    ikey = {64'h0, 64'h1234567890ABCDEF};
    serve("pre_rst", 2'b01, 2'b01, gold_final(64'h1234567890ABCDEF), 1'b0, 15, 1'b0, -1);
    ireq = 2'b01;
    for (int n = 1; n <= 7; n++) tick();
    ireset = 1'b1;
    ireq   = 2'b00;
    tick();
    ireset = 1'b0;
    check("mrst_out", {ogrant, odone, oerr, obusy}, 64'd0);
    check("mrst_okey", okey, 64'd0);
    quiet_bad = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (odone !== 2'b00 || obusy !== 1'b0) quiet_bad++;
    end
    check("mrst_quiet", 64'(quiet_bad), 64'd0);
    ikey = {64'h0, 64'hCAFEBABE00C0FFEE};
    serve("post_rst", 2'b01, 2'b01, gold_final(64'hCAFEBABE00C0FFEE), 1'b0, 15, 1'b0, -1);

    // Withdrawn request: ireq[1] low from cycle 5, service still completes.
    ikey = {64'h0BADF00D13572468, 64'h0};
    serve("wdrw", 2'b10, 2'b10, gold_final(64'h0BADF00D13572468), 1'b0, 15, 1'b0, 5);
    quiet_bad = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (obusy !== 1'b0 || ogrant !== 2'b00) quiet_bad++;
    end
    check("wdrw_no_restart", 64'(quiet_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
